// File: rtl/io_input_port.sv
// io_input_port: memory-mapped input port for the single-cycle computer.
// Synchronizes and debounces 10 slide switches and 4 active-low keys, latches
// key presses in a write-one-to-clear event register, and presents all three
// as read-only words on the data-memory bus.
module io_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [31:0] SW_ADDR         = 32'h0000_0080,
  parameter logic [31:0] KEY_ADDR        = 32'h0000_0084,
  parameter logic [31:0] EDGE_ADDR       = 32'h0000_0088
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        sel,
  output logic        key_event
);

  localparam int unsigned NB = 14;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Bits [9:0] are switches (idle 0), bits [13:10] are keys (idle 1 = released).
  localparam logic [NB-1:0] IN_RST = {4'hF, 10'h000};

  logic [NB-1:0] meta_q;
  logic [NB-1:0] sync_q;
  logic [NB-1:0] stable_q;
  logic [NB-1:0] stable_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [3:0]    event_q;
  logic [3:0]    event_d;
  logic [3:0]    press_s;
  logic [3:0]    clr_s;
  logic          hit_sw;
  logic          hit_key;
  logic          hit_edge;
  logic          unused_bits;

  // Word-address decode; the byte offset addr[1:0] is ignored.
  assign hit_sw   = (addr[31:2] == SW_ADDR[31:2]);
  assign hit_key  = (addr[31:2] == KEY_ADDR[31:2]);
  assign hit_edge = (addr[31:2] == EDGE_ADDR[31:2]);
  assign sel      = hit_sw | hit_key | hit_edge;

  // Only the low four store-data bits are meaningful (event clear mask).
  assign unused_bits = ^{addr[1:0], datain[31:4]};

  // Two-flop synchronizer for every raw input bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= IN_RST;
      sync_q <= IN_RST;
    end else begin
      meta_q <= {key, sw};
      sync_q <= meta_q;
    end
  end

  // Debounce next state: a bit must disagree with its stable value for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable_q <= IN_RST;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Event next state: a stable 1->0 key transition sets the bit in the same
  // edge the stable value flips; a W1C store clears, but a set wins.
  always_comb begin
    press_s = stable_q[13:10] & ~stable_d[13:10];
    if (we && hit_edge) begin
      clr_s = datain[3:0];
    end else begin
      clr_s = 4'h0;
    end
    event_d = (event_q & ~clr_s) | press_s;
  end

  // Key-event register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      event_q <= 4'h0;
    end else begin
      event_q <= event_d;
    end
  end

  assign key_event = |event_q;

  // Read mux, combinational on addr so a single-cycle lw sees it directly.
  always_comb begin
    if (hit_sw) begin
      dataout = {22'd0, stable_q[9:0]};
    end else if (hit_key) begin
      dataout = {28'd0, ~stable_q[13:10]};
    end else if (hit_edge) begin
      dataout = {28'd0, event_q};
    end else begin
      dataout = 32'd0;
    end
  end

endmodule
